// File: rtl/pipelined_control_unit.sv
// Pipelined control unit: single ID decode, registered EX/MEM/WB bundles,
// load-use stall, branch/jump flush, overflow squash and halt drain.
module pipelined_control_unit #(
    parameter int OPW = 4,
    parameter int FCW = 4,
    parameter int RAW = 4,
    parameter logic [FCW-1:0] OP2_FUNCT = 4'b1111,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           id_valid,
    input  logic [OPW-1:0] id_opcode,
    input  logic [FCW-1:0] id_funct,
    input  logic [RAW-1:0] id_rs1,
    input  logic [RAW-1:0] id_rs2,
    input  logic [RAW-1:0] id_rd,
    input  logic           ex_branch_taken,
    input  logic           ex_overflow,
    output logic           stall,
    output logic           flush_ifid,
    output logic           id_branch,
    output logic           id_jump,
    output logic [1:0]     id_offset_select,
    output logic [1:0]     id_branch_select,
    output logic [OPW-1:0] ex_aluop,
    output logic [2:0]     ex_alusrc1,
    output logic [2:0]     ex_alusrc2,
    output logic           mem_read,
    output logic           mem_write,
    output logic           mem_store_byte,
    output logic           wb_reg_write,
    output logic           wb_write_op2,
    output logic [1:0]     wb_mem_to_reg,
    output logic [RAW-1:0] wb_rd,
    output logic           exception,
    output logic           halted
);

    localparam logic [OPW-1:0] OP_A    = OPW'(4'h1);
    localparam logic [OPW-1:0] OP_AND  = OPW'(4'h2);
    localparam logic [OPW-1:0] OP_OR   = OPW'(4'h3);
    localparam logic [OPW-1:0] OP_LBU  = OPW'(4'h4);
    localparam logic [OPW-1:0] OP_SB   = OPW'(4'h5);
    localparam logic [OPW-1:0] OP_LW   = OPW'(4'h6);
    localparam logic [OPW-1:0] OP_SW   = OPW'(4'h7);
    localparam logic [OPW-1:0] OP_JMP  = OPW'(4'h8);
    localparam logic [OPW-1:0] OP_BLT  = OPW'(4'hC);
    localparam logic [OPW-1:0] OP_BGT  = OPW'(4'hD);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(4'hE);
    localparam logic [OPW-1:0] OP_HALT = OPW'(4'hF);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_CYCLES - 1);

    typedef struct packed {
        logic read;
        logic write;
        logic store_byte;
    } mem_t;

    typedef struct packed {
        logic           reg_write;
        logic           write_op2;
        logic [1:0]     mem_to_reg;
        logic [RAW-1:0] rd;
    } wb_t;

    typedef struct packed {
        logic [OPW-1:0] aluop;
        logic [2:0]     alusrc1;
        logic [2:0]     alusrc2;
        logic           branch;
        logic           load;
        logic           alu;
        mem_t           mem;
        wb_t            wb;
    } idex_t;

    typedef struct packed {
        mem_t mem;
        wb_t  wb;
    } exmem_t;

    idex_t   dec;
    idex_t   idex;
    exmem_t  exmem;
    wb_t     memwb;
    logic [1:0]    state;
    logic [CW-1:0] cnt;

    logic is_a, is_and, is_or, is_lbu, is_sb, is_lw, is_sw;
    logic is_jmp, is_blt, is_bgt, is_beq, is_halt;

    assign is_a    = id_valid && (id_opcode == OP_A);
    assign is_and  = id_valid && (id_opcode == OP_AND);
    assign is_or   = id_valid && (id_opcode == OP_OR);
    assign is_lbu  = id_valid && (id_opcode == OP_LBU);
    assign is_sb   = id_valid && (id_opcode == OP_SB);
    assign is_lw   = id_valid && (id_opcode == OP_LW);
    assign is_sw   = id_valid && (id_opcode == OP_SW);
    assign is_jmp  = id_valid && (id_opcode == OP_JMP);
    assign is_blt  = id_valid && (id_opcode == OP_BLT);
    assign is_bgt  = id_valid && (id_opcode == OP_BGT);
    assign is_beq  = id_valid && (id_opcode == OP_BEQ);
    assign is_halt = id_valid && (id_opcode == OP_HALT);

    always_comb begin
        dec = '0;
        id_branch = 1'b0;
        id_jump = 1'b0;
        id_offset_select = 2'b00;
        id_branch_select = 2'b00;
        unique case (1'b1)
            is_a: begin
                dec.aluop = id_opcode;
                dec.alu = 1'b1;
                dec.wb.reg_write = 1'b1;
                dec.wb.write_op2 = (id_funct == OP2_FUNCT);
                dec.wb.rd = id_rd;
            end
            is_and, is_or: begin
                dec.aluop = id_opcode;
                dec.alusrc1 = 3'b001;
                dec.alu = 1'b1;
                dec.wb.reg_write = 1'b1;
                dec.wb.rd = id_rd;
            end
            is_lbu, is_lw: begin
                dec.aluop = id_opcode;
                dec.alusrc2 = 3'b001;
                dec.load = 1'b1;
                dec.mem.read = 1'b1;
                dec.wb.reg_write = 1'b1;
                dec.wb.mem_to_reg = is_lbu ? 2'b10 : 2'b01;
                dec.wb.rd = id_rd;
            end
            is_sb, is_sw: begin
                dec.aluop = id_opcode;
                dec.alusrc2 = 3'b001;
                dec.mem.write = 1'b1;
                dec.mem.store_byte = is_sb;
            end
            is_jmp: begin
                dec.aluop = id_opcode;
                id_jump = 1'b1;
                id_offset_select = 2'b10;
            end
            is_blt, is_bgt, is_beq: begin
                dec.aluop = id_opcode;
                dec.alusrc1 = 3'b010;
                dec.branch = 1'b1;
                id_branch = 1'b1;
                id_offset_select = 2'b01;
                id_branch_select = is_blt ? 2'b00 : (is_bgt ? 2'b01 : 2'b10);
            end
            default: ;
        endcase
    end

    logic ovf_sq, br_flush, load_use, hold, bubble, halt_go;

    assign ovf_sq   = idex.alu && ex_overflow;
    assign br_flush = idex.branch && ex_branch_taken;
    assign load_use = idex.load && id_valid &&
                      ((idex.wb.rd == id_rs1) || (idex.wb.rd == id_rs2));
    assign hold     = (state != S_RUN);
    assign bubble   = ovf_sq || br_flush || load_use || hold;
    assign halt_go  = (state == S_RUN) && is_halt && !bubble;

    // Flush and overflow outrank every stall source
    assign stall      = !rst && !ovf_sq && !br_flush && (load_use || hold);
    assign flush_ifid = !rst && (ovf_sq || br_flush ||
                                 (id_jump && !load_use && !hold));
    assign exception  = !rst && ovf_sq;
    assign halted     = (state == S_HALTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            idex  <= '0;
            exmem <= '0;
            memwb <= '0;
        end else begin
            idex  <= bubble ? '0 : dec;
            exmem <= ovf_sq ? '0 : {idex.mem, idex.wb};
            memwb <= exmem.wb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RUN;
            cnt   <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (halt_go) begin
                        state <= S_DRAIN;
                        cnt   <= '0;
                    end
                end
                S_DRAIN: begin
                    if (cnt == CNT_LAST) begin
                        state <= S_HALTED;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_HALTED: state <= S_HALTED;
                default:  state <= S_RUN;
            endcase
        end
    end

    assign ex_aluop       = idex.aluop;
    assign ex_alusrc1     = idex.alusrc1;
    assign ex_alusrc2     = idex.alusrc2;
    assign mem_read       = exmem.mem.read;
    assign mem_write      = exmem.mem.write;
    assign mem_store_byte = exmem.mem.store_byte;
    assign wb_reg_write   = memwb.reg_write;
    assign wb_write_op2   = memwb.write_op2;
    assign wb_mem_to_reg  = memwb.mem_to_reg;
    assign wb_rd          = memwb.rd;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: decode table, directed hazard
// sequences and a randomized run against an instruction-level model.
module tb_pipelined_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [3:0] id_opcode, id_funct, id_rs1, id_rs2, id_rd;
    logic       ex_branch_taken, ex_overflow;
    logic       stall, flush_ifid, id_branch, id_jump;
    logic [1:0] id_offset_select, id_branch_select;
    logic [3:0] ex_aluop;
    logic [2:0] ex_alusrc1, ex_alusrc2;
    logic       mem_read, mem_write, mem_store_byte;
    logic       wb_reg_write, wb_write_op2;
    logic [1:0] wb_mem_to_reg;
    logic [3:0] wb_rd;
    logic       exception, halted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipelined_control_unit dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_branch_taken(ex_branch_taken), .ex_overflow(ex_overflow),
        .stall(stall), .flush_ifid(flush_ifid),
        .id_branch(id_branch), .id_jump(id_jump),
        .id_offset_select(id_offset_select),
        .id_branch_select(id_branch_select),
        .ex_aluop(ex_aluop), .ex_alusrc1(ex_alusrc1), .ex_alusrc2(ex_alusrc2),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_store_byte(mem_store_byte),
        .wb_reg_write(wb_reg_write), .wb_write_op2(wb_write_op2),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd),
        .exception(exception), .halted(halted)
    );

    typedef struct packed {
        logic [3:0] aluop;
        logic [2:0] src1, src2;
        logic       br, ld, alu;
        logic       mr, mw, sb;
        logic       rw, op2;
        logic [1:0] m2r;
        logic [3:0] rd;
    } rec_t;

    typedef struct packed {
        logic       v;
        logic [3:0] op;
        logic       br, jp;
        logic [1:0] off, bsel;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op,
                         input logic [3:0] fn, input logic [3:0] r1,
                         input logic [3:0] r2, input logic [3:0] rd,
                         input logic bt, input logic ov);
        id_valid = v; id_opcode = op; id_funct = fn;
        id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        ex_branch_taken = bt; ex_overflow = ov;
        #2;
    endtask

    task automatic nop();
        drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nop();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // Expected per-instruction effect, straight from the opcode map
    function automatic rec_t decode(input logic v, input logic [3:0] op,
                                    input logic [3:0] fn, input logic [3:0] rd);
        rec_t r;
        r = '0;
        if (v) begin
            case (op)
                4'h1: begin r.aluop = op; r.alu = 1; r.rw = 1;
                            r.op2 = (fn == 4'hF); r.rd = rd; end
                4'h2, 4'h3: begin r.aluop = op; r.src1 = 3'b001; r.alu = 1;
                                  r.rw = 1; r.rd = rd; end
                4'h4: begin r.aluop = op; r.src2 = 3'b001; r.ld = 1; r.mr = 1;
                            r.rw = 1; r.m2r = 2'b10; r.rd = rd; end
                4'h6: begin r.aluop = op; r.src2 = 3'b001; r.ld = 1; r.mr = 1;
                            r.rw = 1; r.m2r = 2'b01; r.rd = rd; end
                4'h5: begin r.aluop = op; r.src2 = 3'b001; r.mw = 1;
                            r.sb = 1; end
                4'h7: begin r.aluop = op; r.src2 = 3'b001; r.mw = 1; end
                4'h8: r.aluop = op;
                4'hC, 4'hD, 4'hE: begin r.aluop = op; r.src1 = 3'b010;
                                        r.br = 1; end
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    vec_t vt[8];
    rec_t pipe[$];
    int   hage;

    initial begin
        rst = 1'b1;
        nop();
        vt[0] = '{1, 4'hC, 1, 0, 2'b01, 2'b00};
        vt[1] = '{1, 4'hD, 1, 0, 2'b01, 2'b01};
        vt[2] = '{1, 4'hE, 1, 0, 2'b01, 2'b10};
        vt[3] = '{1, 4'h8, 0, 1, 2'b10, 2'b00};
        vt[4] = '{0, 4'h8, 0, 0, 2'b00, 2'b00};
        vt[5] = '{0, 4'hE, 0, 0, 2'b00, 2'b00};
        vt[6] = '{1, 4'h2, 0, 0, 2'b00, 2'b00};
        vt[7] = '{1, 4'h9, 0, 0, 2'b00, 2'b00};
        cyc();
        cyc();

        chk("rst_ex", {ex_aluop, ex_alusrc1, ex_alusrc2}, 0);
        chk("rst_mem", {mem_read, mem_write, mem_store_byte}, 0);
        chk("rst_wb", {wb_reg_write, wb_write_op2, wb_mem_to_reg, wb_rd}, 0);
        chk("rst_ctl", {stall, flush_ifid, exception, halted}, 0);

        for (int i = 0; i < 8; i++) begin
            drive(vt[i].v, vt[i].op, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
            chk($sformatf("dec%0d", i),
                {id_branch, id_jump, id_offset_select, id_branch_select},
                {vt[i].br, vt[i].jp, vt[i].off, vt[i].bsel});
        end
        do_reset();

        // load-use
        drive(1, 4'h6, 0, 0, 0, 4'd3, 0, 0); chk("lu_a_stall", stall, 0); cyc();
        drive(1, 4'h1, 0, 4'd3, 4'd1, 4'd5, 0, 0);
        chk("lu_b_stall", stall, 1); chk("lu_b_ex", ex_aluop, 6);
        chk("lu_b_src2", ex_alusrc2, 1); cyc();
        drive(1, 4'h1, 0, 4'd3, 4'd1, 4'd5, 0, 0);
        chk("lu_c_stall", stall, 0); chk("lu_c_ex", ex_aluop, 0); cyc();
        nop();
        chk("lu_d_ex", ex_aluop, 1);
        chk("lu_d_wb", {wb_reg_write, wb_mem_to_reg, wb_rd}, {1'b1, 2'b01, 4'd3});
        cyc();
        nop(); chk("lu_e_wb", wb_reg_write, 0); cyc();
        nop();
        chk("lu_f_wb", {wb_reg_write, wb_mem_to_reg, wb_rd}, {1'b1, 2'b00, 4'd5});
        cyc();

        // write_op2
        drive(1, 4'h1, 4'hF, 0, 0, 4'd2, 0, 0); cyc();
        drive(1, 4'h2, 4'h0, 0, 0, 4'd4, 0, 0); cyc();
        nop(); chk("op2_ex", {ex_aluop, ex_alusrc1}, {4'h2, 3'b001}); cyc();
        nop();
        chk("op2_wb1", {wb_write_op2, wb_reg_write, wb_rd}, {1'b1, 1'b1, 4'd2});
        cyc();
        nop();
        chk("op2_wb2", {wb_write_op2, wb_reg_write, wb_rd}, {1'b0, 1'b1, 4'd4});
        cyc();

        // taken branch
        drive(1, 4'hE, 0, 0, 0, 0, 0, 0);
        chk("beq_id", {id_branch, id_branch_select, id_offset_select}, 5'b11001);
        cyc();
        drive(1, 4'h1, 0, 0, 0, 4'd6, 1, 0);
        chk("beq_flush", {flush_ifid, stall}, 2'b10);
        chk("beq_ex", {ex_aluop, ex_alusrc1}, {4'hE, 3'b010}); cyc();
        nop(); chk("beq_bubble", {ex_aluop, ex_alusrc1, ex_alusrc2}, 0); cyc();

        // overflow squash
        drive(1, 4'h1, 0, 0, 0, 4'd7, 0, 0); cyc();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        chk("ovf_exc", {exception, flush_ifid}, 2'b11); cyc();
        nop(); chk("ovf_pulse", exception, 0); cyc();
        nop(); chk("ovf_wb", wb_reg_write, 0); cyc();

        // halt drain
        do_reset();
        drive(1, 4'hF, 0, 0, 0, 0, 0, 0); chk("halt_a", {stall, halted}, 0); cyc();
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'hF, 0, 0, 0, 0, 0, 0);
            chk($sformatf("drain%0d", i), {stall, halted}, 2'b10); cyc();
        end
        nop(); chk("halted", {stall, halted}, 2'b11); cyc();
        nop(); chk("halted_stay", halted, 1); cyc();
        do_reset();
        drive(1, 4'hE, 0, 0, 0, 0, 0, 0); cyc();
        drive(1, 4'hF, 0, 0, 0, 0, 1, 0); chk("halt_fl", flush_ifid, 1); cyc();
        for (int i = 0; i < 5; i++) begin
            nop(); chk($sformatf("halt_disc%0d", i), {stall, halted}, 0); cyc();
        end

        // reset mid-drain
        drive(1, 4'hF, 0, 0, 0, 0, 0, 0); cyc();
        drive(1, 4'hF, 0, 0, 0, 0, 0, 0); chk("rd_stall", stall, 1);
        rst = 1'b1; cyc();
        rst = 1'b0;
        drive(1, 4'h5, 0, 0, 0, 0, 0, 0); chk("rd_run", {stall, halted}, 0); cyc();
        nop(); cyc();
        nop(); chk("rd_sb", {mem_write, mem_store_byte, mem_read}, 3'b110); cyc();

        // randomized run against the model
        do_reset();
        pipe = {rec_t'(0), rec_t'(0), rec_t'(0)};
        hage = 0;
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] op;
            logic ovf, br, lu, e_stall, e_flush, jmp, acc;
            rec_t ex, nxt, d;
            rst = ($urandom_range(0, 59) == 0);
            op = 4'($urandom_range(0, 15));
            if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h6;
            drive($urandom_range(0, 7) != 0, op, 4'($urandom_range(14, 15)),
                  4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                  4'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 5) == 0);
            ex = pipe[0];
            d = decode(id_valid, id_opcode, id_funct, id_rd);
            ovf = ex.alu && ex_overflow;
            br = ex.br && ex_branch_taken;
            lu = ex.ld && id_valid && (ex.rd == id_rs1 || ex.rd == id_rs2);
            e_stall = !rst && !ovf && !br && (lu || hage != 0);
            jmp = id_valid && id_opcode == 4'h8;
            e_flush = !rst && (ovf || br || (jmp && !e_stall));
            chk($sformatf("r%0d_ctl", n), {stall, flush_ifid, exception, halted},
                {e_stall, e_flush, !rst && ovf, hage > 3});
            chk($sformatf("r%0d_id", n),
                {id_branch, id_jump, id_offset_select, id_branch_select},
                {d.br, jmp, d.br ? 2'b01 : (jmp ? 2'b10 : 2'b00),
                 !d.br ? 2'b00 : (id_opcode == 4'hC ? 2'b00 :
                                  (id_opcode == 4'hD ? 2'b01 : 2'b10))});
            chk($sformatf("r%0d_ex", n), {ex_aluop, ex_alusrc1, ex_alusrc2},
                {ex.aluop, ex.src1, ex.src2});
            chk($sformatf("r%0d_mem", n), {mem_read, mem_write, mem_store_byte},
                {pipe[1].mr, pipe[1].mw, pipe[1].sb});
            chk($sformatf("r%0d_wb", n),
                {wb_reg_write, wb_write_op2, wb_mem_to_reg, wb_rd},
                {pipe[2].rw, pipe[2].op2, pipe[2].m2r, pipe[2].rd});
            if (rst) begin
                pipe = {rec_t'(0), rec_t'(0), rec_t'(0)};
                hage = 0;
            end else begin
                acc = hage == 0 && id_valid && id_opcode == 4'hF &&
                      !ovf && !br && !lu;
                nxt = (ovf || br || lu || hage != 0) ? rec_t'(0) : d;
                if (ovf) pipe[0] = '0;
                void'(pipe.pop_back());
                pipe.push_front(nxt);
                if (hage != 0) begin
                    if (hage <= 3) hage++;
                end else if (acc) begin
                    hage = 1;
                end
            end
            cyc();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
